// File: rtl/alu_mul_sequencer.sv
// Shift-add multiplier that borrows the core's single ALU for its additions.
// In IDLE/DONE the core drives the ALU directly; in RUN the sequencer owns the
// ALU (acc + mcand, add) and stalls the core. Produces the low WIDTH bits of
// A*B, valid for both signed and unsigned multiplication.
module alu_mul_sequencer #(
  parameter int WIDTH      = 32,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             core_stall_o,
  input  logic [WIDTH-1:0] core_a_i,
  input  logic [WIDTH-1:0] core_b_i,
  input  logic [2:0]       core_ctrl_i,
  output logic [WIDTH-1:0] alu_a_o,
  output logic [WIDTH-1:0] alu_b_o,
  output logic [2:0]       alu_ctrl_o,
  input  logic [WIDTH-1:0] alu_out_i
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [2:0] ALU_ADD = 3'b000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   result_q;

  logic [WIDTH-1:0]   acc_d;
  logic [WIDTH-1:0]   mcand_d;
  logic [WIDTH-1:0]   mplier_d;
  logic               last_iter;

  // Next-state datapath for one RUN iteration; the ALU supplies acc + mcand.
  always_comb begin
    acc_d     = mplier_q[0] ? alu_out_i : acc_q;
    mcand_d   = mcand_q << 1;
    mplier_d  = mplier_q >> 1;
    last_iter = (cnt_q == CNT_W'(WIDTH - 1)) || (EARLY_EXIT && (mplier_d == '0));
  end

  // Sequencer FSM and datapath registers; result only changes on completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            acc_q    <= '0;
            mcand_q  <= op_a_i;
            mplier_q <= op_b_i;
            cnt_q    <= '0;
            state_q  <= S_RUN;
          end else begin
            state_q  <= S_IDLE;
          end
        end
        S_RUN: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_d;
          mplier_q <= mplier_d;
          cnt_q    <= cnt_q + 1'b1;
          if (last_iter) begin
            result_q <= acc_d;
            state_q  <= S_DONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Status outputs are pure decodes of the registered state.
  always_comb begin
    busy_o       = (state_q == S_RUN);
    done_o       = (state_q == S_DONE);
    core_stall_o = (state_q == S_RUN);
    result_o     = result_q;
  end

  // ALU ownership mux: sequencer in RUN, core otherwise.
  always_comb begin
    if (state_q == S_RUN) begin
      alu_a_o    = acc_q;
      alu_b_o    = mcand_q;
      alu_ctrl_o = ALU_ADD;
    end else begin
      alu_a_o    = core_a_i;
      alu_b_o    = core_b_i;
      alu_ctrl_o = core_ctrl_i;
    end
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer: two instances (early exit on / off)
// each wired to a behavioural model of the core ALU.
module tb_alu_mul_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, start2;
  logic [31:0] op_a, op_b, op_a2, op_b2;
  logic [31:0] core_a, core_b;
  logic [2:0]  core_ctrl;

  logic        busy, done, stall, busy2, done2, stall2;
  logic [31:0] result, result2;
  logic [31:0] alu_a, alu_b, alu_out, alu_a2, alu_b2, alu_out2;
  logic [2:0]  alu_ctrl, alu_ctrl2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] c);
    case (c)
      3'b000:  alu_f = a + b;
      3'b001:  alu_f = a - b;
      3'b010:  alu_f = a & b;
      3'b011:  alu_f = a | b;
      3'b101:  alu_f = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: alu_f = 32'd0;
    endcase
  endfunction

  assign alu_out  = alu_f(alu_a, alu_b, alu_ctrl);
  assign alu_out2 = alu_f(alu_a2, alu_b2, alu_ctrl2);

  alu_mul_sequencer #(.WIDTH(32), .EARLY_EXIT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .op_a_i(op_a), .op_b_i(op_b),
    .busy_o(busy), .done_o(done), .result_o(result), .core_stall_o(stall),
    .core_a_i(core_a), .core_b_i(core_b), .core_ctrl_i(core_ctrl),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_ctrl_o(alu_ctrl), .alu_out_i(alu_out)
  );

  alu_mul_sequencer #(.WIDTH(32), .EARLY_EXIT(1'b0)) dut_full (
    .clk(clk), .rst_n(rst_n), .start_i(start2), .op_a_i(op_a2), .op_b_i(op_b2),
    .busy_o(busy2), .done_o(done2), .result_o(result2), .core_stall_o(stall2),
    .core_a_i(core_a), .core_b_i(core_b), .core_ctrl_i(core_ctrl),
    .alu_a_o(alu_a2), .alu_b_o(alu_b2), .alu_ctrl_o(alu_ctrl2), .alu_out_i(alu_out2)
  );

  // Stimulus helper: issue one multiply on the selected instance and wait for
  // done. Returns at the negedge where done is observed.
  task automatic do_mul(input bit sel, input logic [31:0] a, input logic [31:0] b,
                        output int cycles, output logic [31:0] res,
                        output bit got_done, output bit busy_at_done);
    int guard;
    @(negedge clk);
    if (sel) begin op_a2 = a; op_b2 = b; start2 = 1'b1; end
    else     begin op_a  = a; op_b  = b; start  = 1'b1; end
    @(negedge clk);
    start = 1'b0; start2 = 1'b0;
    cycles = 0; got_done = 1'b0; guard = 0; res = '0; busy_at_done = 1'b0;
    while (!got_done && guard < 100) begin
      if (sel ? done2 : done) begin
        got_done     = 1'b1;
        res          = sel ? result2 : result;
        busy_at_done = sel ? busy2 : busy;
      end else begin
        if (sel ? busy2 : busy) cycles++;
        guard++;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b result=%h stall=%b, want 0/0/0/0",
               busy, done, result, stall);
    end
    checks++;
    if (busy2 !== 1'b0 || done2 !== 1'b0 || result2 !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs_full: busy=%b done=%b result=%h, want 0/0/0",
               busy2, done2, result2);
    end
    $display("reset: busy=%b done=%b result=%h", busy, done, result);
  endtask

  task automatic test_basic(input bit sel, input string name, input logic [31:0] a,
                            input logic [31:0] b, input int exp_cycles,
                            input logic [31:0] exp_res);
    int cyc; logic [31:0] res; bit got, bsy;
    do_mul(sel, a, b, cyc, res, got, bsy);
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s_done: no done within bound, want done", name);
    end
    checks++;
    if (cyc !== exp_cycles) begin
      errors++;
      $display("FAIL %s_cycles: got %0d run cycles, want %0d", name, cyc, exp_cycles);
    end
    checks++;
    if (res !== exp_res || bsy !== 1'b0) begin
      errors++;
      $display("FAIL %s_result: got %h busy=%b, want %h busy=0", name, res, bsy, exp_res);
    end
    @(negedge clk);
    checks++;
    if ((sel ? done2 : done) !== 1'b0) begin
      errors++;
      $display("FAIL %s_done_pulse: done still 1 after one cycle, want 0", name);
    end
    $display("mul[%s]: %h * %h -> %h in %0d cycles", name, a, b, res, cyc);
  endtask

  task automatic test_passthrough();
    int guard;
    core_a = 32'd5; core_b = 32'd3; core_ctrl = 3'b001;
    #1;
    checks++;
    if (alu_a !== 32'd5 || alu_b !== 32'd3 || alu_ctrl !== 3'b001 || stall !== 1'b0) begin
      errors++;
      $display("FAIL idle_pass: alu a=%h b=%h ctrl=%b stall=%b, want 5/3/001/0",
               alu_a, alu_b, alu_ctrl, stall);
    end
    @(negedge clk);
    op_a = 32'h11; op_b = 32'h3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (alu_ctrl !== 3'b000 || stall !== 1'b1 || alu_a !== 32'd0 || alu_b !== 32'h11) begin
      errors++;
      $display("FAIL run_mux: alu a=%h b=%h ctrl=%b stall=%b, want 0/11/000/1",
               alu_a, alu_b, alu_ctrl, stall);
    end
    guard = 0;
    while (!done && guard < 100) begin guard++; @(negedge clk); end
    checks++;
    if (!done || result !== 32'h33 || alu_ctrl !== 3'b001 || alu_a !== 32'd5) begin
      errors++;
      $display("FAIL done_mux: done=%b result=%h ctrl=%b a=%h, want 1/33/001/5",
               done, result, alu_ctrl, alu_a);
    end
    $display("passthrough: idle/run/done mux sequence done, result=%h", result);
  endtask

  task automatic test_start_ignored();
    int cyc, guard; bit got;
    @(negedge clk);
    op_a = 32'd3; op_b = 32'h100; start = 1'b1;
    @(negedge clk);
    start = 1'b0; cyc = 0; guard = 0; got = 1'b0;
    while (!got && guard < 100) begin
      if (done) got = 1'b1;
      else begin
        if (busy) cyc++;
        start = (cyc == 2);
        if (cyc == 2) begin op_a = 32'd5; op_b = 32'd5; end
        guard++;
        @(negedge clk);
      end
    end
    start = 1'b0;
    checks++;
    if (!got || cyc !== 9 || result !== 32'h300) begin
      errors++;
      $display("FAIL start_mid_run: done=%b cycles=%0d result=%h, want 1/9/300",
               got, cyc, result);
    end
    $display("start mid-run: cycles=%0d result=%h", cyc, result);
  endtask

  task automatic test_back_to_back();
    int cyc; logic [31:0] res; bit got, bsy;
    int guard;
    do_mul(1'b0, 32'd6, 32'd7, cyc, res, got, bsy);
    op_a = 32'd9; op_b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || result !== 32'd42) begin
      errors++;
      $display("FAIL b2b_restart: busy=%b result=%0d, want 1/42", busy, result);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || result !== 32'd42) begin
      errors++;
      $display("FAIL b2b_hold: busy=%b result=%0d, want 1/42", busy, result);
    end
    guard = 0;
    while (!done && guard < 100) begin guard++; @(negedge clk); end
    checks++;
    if (!done || result !== 32'd27) begin
      errors++;
      $display("FAIL b2b_result: done=%b result=%0d, want 1/27", done, result);
    end
    $display("back-to-back: 6*7 then 9*3 -> %0d", result);
  endtask

  task automatic test_reset_mid_run();
    bit seen;
    @(negedge clk);
    op_a = 32'h55; op_b = 32'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_run: busy=%b done=%b result=%h stall=%b, want 0/0/0/0",
               busy, done, result, stall);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL reset_no_done: busy/done seen after aborted run, want none");
    end
    $display("reset mid-run: aborted, idle afterwards=%b", !seen);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; start2 = 1'b0;
    op_a = '0; op_b = '0; op_a2 = '0; op_b2 = '0;
    core_a = '0; core_b = '0; core_ctrl = 3'b000;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;

    test_basic(1'b0, "6x7",      32'd6,        32'd7,        3,  32'd42);
    test_basic(1'b0, "ones",     32'hFFFFFFFF, 32'hFFFFFFFF, 32, 32'h00000001);
    test_basic(1'b0, "zero_b",   32'h1234,     32'd0,        1,  32'd0);
    test_basic(1'b1, "full_b1",  32'hDEADBEEF, 32'd1,        32, 32'hDEADBEEF);
    test_basic(1'b1, "full_6x7", 32'd6,        32'd7,        32, 32'd42);
    test_basic(1'b0, "neg",      32'hFFFFFFFD, 32'd5,        3,  32'hFFFFFFF1);
    test_passthrough();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_run();
    test_basic(1'b0, "9x9",      32'd9,        32'd9,        4,  32'd81);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
